function_expander_n: RTL and testbench

- Parametrised successor of the function expander: accepts one call packet, fetches an N-argument function descriptor from memory through the cache, and emits a packet-request stream.
- The stream is: coloring, returning, NUM_ARGS argument requests, then exec.
- Descriptor fetch is pipelined: address issue, data return and packet-request emission overlap.
- Sits between the packet router and the packet-request network.

---
 rtl/function_expander_n_pkg.sv | 62 ++++++
 rtl/function_expander_n_fn_desc_buffer.sv | 50 +++++
 rtl/function_expander_n.sv | 189 ++++++++++++++++++
 tb/tb_function_expander_n.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/function_expander_n_pkg.sv
// Shared definitions for the N-argument function expander: packet field layout,
// descriptor field slices, packet-request packing and FSM state encoding.
package function_expander_n_pkg;

   localparam int COLOR_W = 16;
   localparam int OPT_W   = 3;
   localparam int DADDR_W = 16;
   localparam int OPC_W   = 8;
   localparam int ARG_W   = 32;
   localparam int DESC_W  = OPT_W + DADDR_W;
   localparam int PACKET_REQUEST_WIDTH = OPT_W + DADDR_W + COLOR_W + 2 * ARG_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fe_state_e;

   // Call packet, LSB first: data[0..n-1], opcode, dest addr, dest option, color.
   function automatic int pkt_n_width(input int n);
      return COLOR_W + OPT_W + DADDR_W + OPC_W + n * ARG_W;
   endfunction

   function automatic int pkt_arg_lsb(input int k);
      return k * ARG_W;
   endfunction

   function automatic int pkt_opc_lsb(input int n);
      return n * ARG_W;
   endfunction

   function automatic int pkt_daddr_lsb(input int n);
      return pkt_opc_lsb(n) + OPC_W;
   endfunction

   function automatic int pkt_opt_lsb(input int n);
      return pkt_daddr_lsb(n) + DADDR_W;
   endfunction

   function automatic int pkt_color_lsb(input int n);
      return pkt_opt_lsb(n) + OPT_W;
   endfunction

   function automatic logic [OPT_W-1:0] desc_opt(input logic [DESC_W-1:0] w);
      return w[18:16];
   endfunction

   function automatic logic [DADDR_W-1:0] desc_addr(input logic [DESC_W-1:0] w);
      return w[15:0];
   endfunction

   function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
      input logic [OPT_W-1:0]   opt,
      input logic [DADDR_W-1:0] addr,
      input logic [COLOR_W-1:0] color,
      input logic [ARG_W-1:0]   d1,
      input logic [ARG_W-1:0]   d2
   );
      return {opt, addr, color, d1, d2};
   endfunction

endpackage

// File: rtl/function_expander_n_fn_desc_buffer.sv
// Descriptor buffer: DEPTH entries written by return index, read by send index,
// cleared by the asynchronous reset.
module fn_desc_buffer
   import function_expander_n_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = DESC_W,
   parameter int IDX_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Entry storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
               mem_q[i] <= wr_data_i;
            end else begin
               mem_q[i] <= mem_q[i];
            end
         end
      end
   end

   // Read mux
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_idx_i == IDX_W'(i)) begin
            rd_data_o = mem_q[i];
         end else begin
            rd_data_o = rd_data_o;
         end
      end
   end

endmodule

// File: rtl/function_expander_n.sv
// Function expander: latches one call packet, fetches NUM_ARGS+3 descriptor words
// with pipelined reads and emits coloring, returning, argument and exec requests.
module function_expander_n
   import function_expander_n_pkg::*;
#(
   parameter  int NUM_ARGS        = 2,
   parameter  int COLOR_WIDTH     = 16,
   parameter  int DESC_SHIFT      = 4,
   parameter  int MAX_OUTSTANDING = 2,
   localparam int PKT_N_WIDTH     = pkt_n_width(NUM_ARGS)
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic [31:0]                     FNADDR,
   output logic                            MEM_SEND_ADDR_VALID,
   output logic [31:0]                     MEM_SEND_ADDR,
   output logic                            MEM_SEND_DATA_VALID,
   output logic [31:0]                     MEM_SEND_DATA,
   input  logic                            MEM_SEND_READY,
   input  logic                            MEM_RECEIVE_VALID,
   input  logic [31:0]                     MEM_RECEIVE_DATA,
   output logic                            MEM_RECEIVE_READY,
   input  logic                            RECEIVE_PC_VALID,
   input  logic [PKT_N_WIDTH-1:0]          RECEIVE_PC_DATA,
   output logic                            RECEIVE_PC_READY,
   output logic                            SEND_PR_VALID,
   output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
   input  logic                            SEND_PR_READY
);

   localparam int NW        = NUM_ARGS + 3;
   localparam int CNT_W     = $clog2(NW + 1);
   localparam int OPC_LSB   = pkt_opc_lsb(NUM_ARGS);
   localparam int DADDR_LSB = pkt_daddr_lsb(NUM_ARGS);
   localparam int OPT_LSB   = pkt_opt_lsb(NUM_ARGS);
   localparam int COLOR_LSB = pkt_color_lsb(NUM_ARGS);
   localparam logic [CNT_W-1:0] NW_C   = CNT_W'(NW);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NW - 1);
   localparam logic [CNT_W-1:0] MAXO_C = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   fe_state_e                 state_q, state_d;
   logic [PKT_N_WIDTH-1:0]    pkt_q, pkt_d;
   logic [COLOR_WIDTH-1:0]    color_ctr_q, color_ctr_d;
   logic [COLOR_WIDTH-1:0]    new_color_q, new_color_d;
   logic [CNT_W-1:0]          iss_q, iss_d, rcv_q, rcv_d, snd_q, snd_d;
   logic                      pc_ready_q, pc_ready_d;

   logic                      busy_s, accept_s, iss_hs_s, rcv_hs_s, snd_hs_s;
   logic [DESC_W-1:0]         rd_data_s;
   logic [ARG_W-1:0]          arg_s;
   logic [COLOR_W-1:0]        pkt_color_s;
   logic [PACKET_REQUEST_WIDTH-1:0] pr_s;
   logic                      unused_s;

   assign busy_s   = (state_q == ST_BUSY);
   assign accept_s = (state_q == ST_IDLE) && pc_ready_q && RECEIVE_PC_VALID;

   // Outstanding reads are iss-rcv; the limit gates only the issue side.
   assign MEM_SEND_ADDR_VALID = busy_s && (iss_q < NW_C) && ((iss_q - rcv_q) < MAXO_C);
   assign MEM_SEND_ADDR       = FNADDR + (32'(pkt_q[OPC_LSB +: OPC_W]) << DESC_SHIFT)
                                + (32'(iss_q) << 2);
   assign MEM_SEND_DATA_VALID = 1'b0;
   assign MEM_SEND_DATA       = 32'h0000_0000;
   assign MEM_RECEIVE_READY   = busy_s && (rcv_q < iss_q);
   assign SEND_PR_VALID       = busy_s && (snd_q < rcv_q);
   assign SEND_PR_DATA        = pr_s;
   assign RECEIVE_PC_READY    = pc_ready_q;

   assign iss_hs_s = MEM_SEND_ADDR_VALID && MEM_SEND_READY;
   assign rcv_hs_s = MEM_RECEIVE_VALID && MEM_RECEIVE_READY;
   assign snd_hs_s = SEND_PR_VALID && SEND_PR_READY;
   assign unused_s = ^MEM_RECEIVE_DATA[31:DESC_W];

   fn_desc_buffer #(
      .DEPTH (NW),
      .WIDTH (DESC_W),
      .IDX_W (CNT_W)
   ) u_desc_buf (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .wr_en_i   (rcv_hs_s),
      .wr_idx_i  (rcv_q),
      .wr_data_i (MEM_RECEIVE_DATA[DESC_W-1:0]),
      .rd_idx_i  (snd_q),
      .rd_data_o (rd_data_s)
   );

   // Next-state logic for the call FSM and the three pipeline counters
   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      color_ctr_d = color_ctr_q;
      new_color_d = new_color_q;
      iss_d       = iss_q;
      rcv_d       = rcv_q;
      snd_d       = snd_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               pkt_d       = RECEIVE_PC_DATA;
               new_color_d = color_ctr_q;
               color_ctr_d = color_ctr_q + COLOR_WIDTH'(1);
               state_d     = ST_BUSY;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_BUSY: begin
            iss_d = iss_hs_s ? (iss_q + ONE_C) : iss_q;
            rcv_d = rcv_hs_s ? (rcv_q + ONE_C) : rcv_q;
            snd_d = snd_hs_s ? (snd_q + ONE_C) : snd_q;
            if (snd_hs_s && (snd_q == LAST_C)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            iss_d   = '0;
            rcv_d   = '0;
            snd_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            iss_d   = '0;
            rcv_d   = '0;
            snd_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      pc_ready_d = (state_d == ST_IDLE);
   end

   // Packet-request assembly for the current send slot
   always_comb begin
      arg_s       = '0;
      pkt_color_s = pkt_q[COLOR_LSB +: COLOR_W];
      for (int k = 0; k < NUM_ARGS; k++) begin
         if (snd_q == CNT_W'(k + 2)) begin
            arg_s = pkt_q[k * ARG_W +: ARG_W];
         end else begin
            arg_s = arg_s;
         end
      end
      case (snd_q)
         '0:
            pr_s = make_packet_request(desc_opt(rd_data_s), desc_addr(rd_data_s),
                                       COLOR_W'(new_color_q), ARG_W'(pkt_color_s),
                                       32'h0000_0000);
         ONE_C:
            pr_s = make_packet_request(desc_opt(rd_data_s), desc_addr(rd_data_s),
                                       pkt_color_s,
                                       ARG_W'({pkt_q[OPT_LSB +: OPT_W],
                                               pkt_q[DADDR_LSB +: DADDR_W]}),
                                       32'h0000_0000);
         LAST_C:
            pr_s = make_packet_request(desc_opt(rd_data_s), desc_addr(rd_data_s),
                                       pkt_color_s, 32'h0000_0000, 32'h0000_0000);
         default:
            pr_s = make_packet_request(desc_opt(rd_data_s), desc_addr(rd_data_s),
                                       pkt_color_s, arg_s, 32'h0000_0000);
      endcase
   end

   // State, packet, color and counter registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         pkt_q       <= '0;
         color_ctr_q <= '0;
         new_color_q <= '0;
         iss_q       <= '0;
         rcv_q       <= '0;
         snd_q       <= '0;
         pc_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_q       <= pkt_d;
         color_ctr_q <= color_ctr_d;
         new_color_q <= new_color_d;
         iss_q       <= iss_d;
         rcv_q       <= rcv_d;
         snd_q       <= snd_d;
         pc_ready_q  <= pc_ready_d;
      end
   end

endmodule

// File: tb/tb_function_expander_n.sv
// Self-checking bench for function_expander_n: randomized memory/sink timing
// against a queue-based reference model of the call expansion.
`timescale 1ns/1ps
module tb_function_expander_n;

   localparam int NA  = 2;
   localparam int CW  = 2;
   localparam int DS  = 4;
   localparam int MO  = 2;
   localparam int NW  = NA + 3;
   localparam int PKW = 16 + 3 + 16 + 8 + 32 * NA;
   localparam int PRW = 3 + 16 + 16 + 32 + 32;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic [31:0]     FNADDR;
   logic            MEM_SEND_ADDR_VALID;
   logic [31:0]     MEM_SEND_ADDR;
   logic            MEM_SEND_DATA_VALID;
   logic [31:0]     MEM_SEND_DATA;
   logic            MEM_SEND_READY;
   logic            MEM_RECEIVE_VALID;
   logic [31:0]     MEM_RECEIVE_DATA;
   logic            MEM_RECEIVE_READY;
   logic            RECEIVE_PC_VALID;
   logic [PKW-1:0]  RECEIVE_PC_DATA;
   logic            RECEIVE_PC_READY;
   logic            SEND_PR_VALID;
   logic [PRW-1:0]  SEND_PR_DATA;
   logic            SEND_PR_READY;

   function_expander_n #(
      .NUM_ARGS        (NA),
      .COLOR_WIDTH     (CW),
      .DESC_SHIFT      (DS),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .CLK                 (CLK),
      .RST_N               (RST_N),
      .FNADDR              (FNADDR),
      .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
      .MEM_SEND_ADDR       (MEM_SEND_ADDR),
      .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
      .MEM_SEND_DATA       (MEM_SEND_DATA),
      .MEM_SEND_READY      (MEM_SEND_READY),
      .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
      .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
      .MEM_RECEIVE_READY   (MEM_RECEIVE_READY),
      .RECEIVE_PC_VALID    (RECEIVE_PC_VALID),
      .RECEIVE_PC_DATA     (RECEIVE_PC_DATA),
      .RECEIVE_PC_READY    (RECEIVE_PC_READY),
      .SEND_PR_VALID       (SEND_PR_VALID),
      .SEND_PR_DATA        (SEND_PR_DATA),
      .SEND_PR_READY       (SEND_PR_READY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          t;
      logic [31:0] d;
   } ret_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          nc_model = 0;
   int unsigned salt = 0;
   ret_t        mq[$];
   logic [31:0] exp_addr[$];
   logic [PRW-1:0] exp_pr[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   function automatic logic [PRW-1:0] pr_word(input logic [2:0] opt, input logic [15:0] da,
                                              input logic [15:0] col, input logic [31:0] d1);
      return {opt, da, col, d1, 32'h0000_0000};
   endfunction

   task automatic accept(input logic [PKW-1:0] p);
      int waited = 0;
      while (RECEIVE_PC_READY !== 1'b1 && waited < 30) begin
         step();
         waited++;
      end
      chk("pc_ready_idle", RECEIVE_PC_READY, 1'b1);
      RECEIVE_PC_VALID = 1'b1;
      RECEIVE_PC_DATA  = p;
      step();
      RECEIVE_PC_VALID = 1'b0;
      RECEIVE_PC_DATA  = {$urandom, $urandom, $urandom, $urandom};
      chk("pc_ready_after_accept", RECEIVE_PC_READY, 1'b0);
   endtask

   task automatic run_packet(input logic [31:0] fa, input logic [7:0] opc,
                             input int lat_min, input int lat_max,
                             input int mrdy_pct, input int prdy_pct, input bit stall_arg);
      logic [15:0] pc;
      logic [2:0]  popt;
      logic [15:0] pda;
      logic [31:0] a [NA];
      logic [31:0] w;
      logic        av, rr, pv, prev_av, prev_ardy, prev_pv, prev_prdy;
      logic [31:0] aa, prev_aa;
      logic [PRW-1:0] pd, prev_pd;
      int iss, rcv, snd, stall_left;

      pc   = 16'($urandom);
      popt = 3'($urandom);
      pda  = 16'($urandom);
      for (int k = 0; k < NA; k++) a[k] = $urandom;
      salt   = $urandom;
      FNADDR = fa;

      exp_addr.delete();
      exp_pr.delete();
      for (int i = 0; i < NW; i++) exp_addr.push_back(fa + (32'(opc) << DS) + 32'(4 * i));
      for (int i = 0; i < NW; i++) begin
         w = mem_word(exp_addr[i]);
         if (i == 0)           exp_pr.push_back(pr_word(w[18:16], w[15:0], 16'(nc_model), 32'(pc)));
         else if (i == 1)      exp_pr.push_back(pr_word(w[18:16], w[15:0], pc, 32'({popt, pda})));
         else if (i == NW - 1) exp_pr.push_back(pr_word(w[18:16], w[15:0], pc, 32'h0));
         else                  exp_pr.push_back(pr_word(w[18:16], w[15:0], pc, a[i - 2]));
      end
      nc_model = (nc_model + 1) % (1 << CW);

      accept({pc, popt, pda, opc, a[1], a[0]});

      iss = 0; rcv = 0; snd = 0;
      prev_av = 1'b0; prev_ardy = 1'b1; prev_pv = 1'b0; prev_prdy = 1'b1;
      prev_aa = '0; prev_pd = '0;
      stall_left = stall_arg ? 4 : 0;
      for (int c = 0; c < 300 && snd < NW; c++) begin
         av = MEM_SEND_ADDR_VALID; aa = MEM_SEND_ADDR;
         rr = MEM_RECEIVE_READY;
         pv = SEND_PR_VALID;       pd = SEND_PR_DATA;
         chk("addr_valid", av, (iss < NW) && ((iss - rcv) < MO));
         chk("rcv_ready", rr, rcv < iss);
         chk("pr_valid", pv, snd < rcv);
         chk("pc_ready_busy", RECEIVE_PC_READY, 1'b0);
         if (prev_av && !prev_ardy) chk("addr_stable", aa, prev_aa);
         if (prev_pv && !prev_prdy) chk("pr_stable", pd, prev_pd);

         MEM_SEND_READY = ($urandom_range(0, 99) < mrdy_pct);
         if (mq.size() > 0 && mq[0].t <= cyc) begin
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = mq[0].d;
         end else begin
            MEM_RECEIVE_VALID = 1'b0;
            MEM_RECEIVE_DATA  = $urandom;
         end
         if (stall_left > 0 && snd == 2 && pv) begin
            SEND_PR_READY = 1'b0;
            stall_left--;
         end else begin
            SEND_PR_READY = ($urandom_range(0, 99) < prdy_pct);
         end

         if (av && MEM_SEND_READY) begin
            chk($sformatf("mem_addr%0d", iss), aa, exp_addr[iss]);
            mq.push_back('{cyc + $urandom_range(lat_min, lat_max), mem_word(aa)});
            iss++;
         end
         if (MEM_RECEIVE_VALID && rr) begin
            void'(mq.pop_front());
            rcv++;
         end
         if (pv && SEND_PR_READY) begin
            chk($sformatf("pr%0d", snd), pd, exp_pr[snd]);
            snd++;
         end
         prev_av = av; prev_ardy = MEM_SEND_READY; prev_aa = aa;
         prev_pv = pv; prev_prdy = SEND_PR_READY;  prev_pd = pd;
         step();
      end
      chk("exec_sent", snd, NW);
      MEM_RECEIVE_VALID = 1'b0;
      SEND_PR_READY     = 1'b0;
      chk("pc_ready_done", RECEIVE_PC_READY, 1'b0);
      chk("addr_valid_done", MEM_SEND_ADDR_VALID, 1'b0);
      step();
      chk("pc_ready_rise", RECEIVE_PC_READY, 1'b1);
   endtask

   initial begin
      FNADDR            = 32'h0000_1000;
      MEM_SEND_READY    = 1'b0;
      MEM_RECEIVE_VALID = 1'b0;
      MEM_RECEIVE_DATA  = 32'h0;
      RECEIVE_PC_VALID  = 1'b0;
      RECEIVE_PC_DATA   = '0;
      SEND_PR_READY     = 1'b0;
      RST_N             = 1'b0;
      step();
      step();
      chk("rst_addr_valid", MEM_SEND_ADDR_VALID, 1'b0);
      chk("rst_rcv_ready", MEM_RECEIVE_READY, 1'b0);
      chk("rst_pr_valid", SEND_PR_VALID, 1'b0);
      chk("rst_pc_ready", RECEIVE_PC_READY, 1'b0);
      chk("rst_send_data_valid", MEM_SEND_DATA_VALID, 1'b0);
      chk("rst_pr_data", SEND_PR_DATA, '0);
      RST_N = 1'b1;
      step();
      chk("pc_ready_after_rst", RECEIVE_PC_READY, 1'b1);

      run_packet(32'h0000_1000, 8'h03, 1, 1, 100, 100, 1'b0);
      run_packet(32'h0000_1000, 8'h07, 3, 3, 100, 100, 1'b0);
      run_packet(32'h0000_1000, 8'h03, 1, 1, 100, 100, 1'b1);
      run_packet(32'h0000_1000, 8'($urandom), 1, 4, 70, 70, 1'b0);
      run_packet(32'h0000_1000, 8'($urandom), 1, 4, 70, 70, 1'b0);
      run_packet(32'hFFFF_FF00, 8'hF0, 1, 3, 60, 60, 1'b0);

      // Abandon a call with one read in flight, then present a stale return.
      FNADDR = 32'h0000_2000;
      accept({16'h1234, 3'd5, 16'hBEEF, 8'h05, 32'h1111_1111, 32'h2222_2222});
      MEM_SEND_READY = 1'b1;
      SEND_PR_READY  = 1'b1;
      chk("mid_addr_valid", MEM_SEND_ADDR_VALID, 1'b1);
      chk("mid_addr", MEM_SEND_ADDR, 32'h0000_2050);
      step();
      MEM_SEND_READY = 1'b0;
      chk("mid_outstanding", MEM_RECEIVE_READY, 1'b1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_addr_valid", MEM_SEND_ADDR_VALID, 1'b0);
      chk("async_rcv_ready", MEM_RECEIVE_READY, 1'b0);
      chk("async_pr_valid", SEND_PR_VALID, 1'b0);
      chk("async_pc_ready", RECEIVE_PC_READY, 1'b0);
      MEM_RECEIVE_VALID = 1'b1;
      MEM_RECEIVE_DATA  = 32'h0007_FFFF;
      step();
      RST_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stale_not_acked", MEM_RECEIVE_READY, 1'b0);
      end
      MEM_RECEIVE_VALID = 1'b0;
      SEND_PR_READY     = 1'b0;
      mq.delete();
      nc_model = 0;
      run_packet(32'h0000_1000, 8'h03, 1, 2, 80, 80, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
